// File: rtl/ethernet_flash_gpio_if_if.sv
// Single-beat CPU bus between the uncached arbiter and the peripheral bridge.
// Strobes are held by the master until the one-cycle ready pulse.
`timescale 1ns / 1ps

interface ethernet_flash_gpio_if_if;
    logic [23:0] bus_addr;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_addr, bus_read, bus_write, bus_wdata, bus_be,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_addr, bus_read, bus_write, bus_wdata, bus_be,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/ethernet_flash_gpio_if.sv
// ThinPad peripheral bridge: GPIO registers, async NOR-flash reads and DM9000-style
// Ethernet register accesses behind one single-beat bus. All pin outputs are registered.
`timescale 1ns / 1ps

module ethernet_flash_gpio_if #(
    parameter int unsigned FLASH_WAIT  = 6,
    parameter int unsigned ETH_WAIT    = 4,
    parameter int unsigned ETH_RECOVER = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ethernet_flash_gpio_if_if.slave  bus,
    input  logic [31:0]              dip_sw_i,
    output logic [15:0]              leds_o,
    output logic [7:0]               dpy0_o,
    output logic [7:0]               dpy1_o,
    output logic [22:0]              flash_a_o,
    inout  wire  [15:0]              flash_d_io,
    output logic                     flash_ce_n_o,
    output logic                     flash_oe_n_o,
    output logic                     flash_we_n_o,
    output logic                     flash_rp_n_o,
    output logic                     flash_vpen_o,
    output logic                     flash_byte_n_o,
    output logic                     eth_cmd_o,
    output logic                     eth_cs_n_o,
    output logic                     eth_ior_n_o,
    output logic                     eth_iow_n_o,
    output logic                     eth_pwrst_n_o,
    inout  wire  [15:0]              eth_sd_io,
    input  logic                     eth_int_i
);

    localparam int unsigned MaxFe   = (FLASH_WAIT > ETH_WAIT) ? FLASH_WAIT : ETH_WAIT;
    localparam int unsigned MaxWait = (MaxFe > ETH_RECOVER) ? MaxFe : ETH_RECOVER;
    localparam int unsigned CntW    = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;
    localparam int unsigned RecLd   = (ETH_RECOVER > 0) ? ETH_RECOVER - 1 : 0;

    localparam logic [CntW-1:0] FlashLoad = CntW'(FLASH_WAIT - 1);
    localparam logic [CntW-1:0] EthLoad   = CntW'(ETH_WAIT - 1);
    localparam logic [CntW-1:0] RecLoad   = CntW'(RecLd);

    typedef enum logic [2:0] {
        StIdle, StGpio, StFlash, StEth, StDone, StRecover
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ready_q, ready_d;
    logic [31:0]     rdata_q, rdata_d;
    logic [15:0]     leds_q, leds_d;
    logic [7:0]      dpy0_q, dpy0_d;
    logic [7:0]      dpy1_q, dpy1_d;
    logic [22:0]     flash_a_q, flash_a_d;
    logic            flash_en_n_q, flash_en_n_d;
    logic            eth_cmd_q, eth_cmd_d;
    logic            eth_cs_n_q, eth_cs_n_d;
    logic            eth_ior_n_q, eth_ior_n_d;
    logic            eth_iow_n_q, eth_iow_n_d;
    logic [15:0]     eth_sd_q, eth_sd_d;
    logic            eth_sd_oe_q, eth_sd_oe_d;
    logic            acc_eth_q, acc_eth_d;
    logic            run_q;

    logic [1:0]      region;
    logic            req;
    logic [31:0]     gpio_rdata;
    logic            unused_bits;

    assign region      = bus.bus_addr[23:22];
    assign req         = bus.bus_read | bus.bus_write;
    assign unused_bits = ^{bus.bus_addr[0], bus.bus_be[3:2], bus.bus_wdata[31:16]};

    always_comb begin
        gpio_rdata = '0;
        case (bus.bus_addr[4:2])
            3'd0:    gpio_rdata = dip_sw_i;
            3'd1:    gpio_rdata = {16'b0, leds_q};
            3'd2:    gpio_rdata = {24'b0, dpy0_q};
            3'd3:    gpio_rdata = {24'b0, dpy1_q};
            3'd4:    gpio_rdata = {31'b0, eth_int_i};
            default: gpio_rdata = '0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ready_d      = 1'b0;
        rdata_d      = '0;
        leds_d       = leds_q;
        dpy0_d       = dpy0_q;
        dpy1_d       = dpy1_q;
        flash_a_d    = flash_a_q;
        flash_en_n_d = flash_en_n_q;
        eth_cmd_d    = eth_cmd_q;
        eth_cs_n_d   = eth_cs_n_q;
        eth_ior_n_d  = eth_ior_n_q;
        eth_iow_n_d  = eth_iow_n_q;
        eth_sd_d     = eth_sd_q;
        eth_sd_oe_d  = eth_sd_oe_q;
        acc_eth_d    = acc_eth_q;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    acc_eth_d = 1'b0;
                    // Flash reads take the timed path; flash writes are acked like GPIO.
                    if (region == 2'b01 && !bus.bus_write) begin
                        state_d      = StFlash;
                        cnt_d        = FlashLoad;
                        flash_en_n_d = 1'b0;
                        flash_a_d    = {bus.bus_addr[21:1], 1'b0};
                    end else if (region == 2'b10) begin
                        state_d    = StEth;
                        cnt_d      = EthLoad;
                        acc_eth_d  = 1'b1;
                        eth_cs_n_d = 1'b0;
                        eth_cmd_d  = bus.bus_addr[2];
                        if (bus.bus_write) begin
                            eth_iow_n_d = 1'b0;
                            eth_sd_d    = bus.bus_wdata[15:0];
                            eth_sd_oe_d = 1'b1;
                        end else begin
                            eth_ior_n_d = 1'b0;
                        end
                    end else begin
                        // The GPIO state is itself the single completion cycle.
                        state_d = StGpio;
                        ready_d = 1'b1;
                        if (region == 2'b00 && !bus.bus_write) begin
                            rdata_d = gpio_rdata;
                        end
                    end
                end
            end
            StGpio: begin
                state_d = StIdle;
                if (region == 2'b00 && bus.bus_write) begin
                    case (bus.bus_addr[4:2])
                        3'd1: begin
                            if (bus.bus_be[0]) leds_d[7:0]  = bus.bus_wdata[7:0];
                            if (bus.bus_be[1]) leds_d[15:8] = bus.bus_wdata[15:8];
                        end
                        3'd2:    if (bus.bus_be[0]) dpy0_d = bus.bus_wdata[7:0];
                        3'd3:    if (bus.bus_be[0]) dpy1_d = bus.bus_wdata[7:0];
                        default: ;
                    endcase
                end
            end
            StFlash: begin
                if (cnt_q == '0) begin
                    state_d      = StDone;
                    flash_en_n_d = 1'b1;
                    ready_d      = 1'b1;
                    rdata_d      = {16'b0, flash_d_io};
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StEth: begin
                if (cnt_q == '0) begin
                    state_d     = StDone;
                    eth_cs_n_d  = 1'b1;
                    eth_ior_n_d = 1'b1;
                    eth_iow_n_d = 1'b1;
                    ready_d     = 1'b1;
                    if (!eth_ior_n_q) begin
                        rdata_d = {16'b0, eth_sd_io};
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                // Write data stays on the bus one cycle past the iow_n rising edge.
                eth_sd_oe_d = 1'b0;
                if (acc_eth_q && (ETH_RECOVER > 0)) begin
                    state_d = StRecover;
                    cnt_d   = RecLoad;
                end else begin
                    state_d = StIdle;
                end
            end
            StRecover: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            rdata_q      <= '0;
            leds_q       <= '0;
            dpy0_q       <= '0;
            dpy1_q       <= '0;
            flash_a_q    <= '0;
            flash_en_n_q <= 1'b1;
            eth_cmd_q    <= 1'b0;
            eth_cs_n_q   <= 1'b1;
            eth_ior_n_q  <= 1'b1;
            eth_iow_n_q  <= 1'b1;
            eth_sd_q     <= '0;
            eth_sd_oe_q  <= 1'b0;
            acc_eth_q    <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            rdata_q      <= rdata_d;
            leds_q       <= leds_d;
            dpy0_q       <= dpy0_d;
            dpy1_q       <= dpy1_d;
            flash_a_q    <= flash_a_d;
            flash_en_n_q <= flash_en_n_d;
            eth_cmd_q    <= eth_cmd_d;
            eth_cs_n_q   <= eth_cs_n_d;
            eth_ior_n_q  <= eth_ior_n_d;
            eth_iow_n_q  <= eth_iow_n_d;
            eth_sd_q     <= eth_sd_d;
            eth_sd_oe_q  <= eth_sd_oe_d;
            acc_eth_q    <= acc_eth_d;
            run_q        <= 1'b1;
        end
    end

    assign bus.bus_ready  = ready_q;
    assign bus.bus_rdata  = rdata_q;
    assign leds_o         = leds_q;
    assign dpy0_o         = dpy0_q;
    assign dpy1_o         = dpy1_q;
    assign flash_a_o      = flash_a_q;
    assign flash_ce_n_o   = flash_en_n_q;
    assign flash_oe_n_o   = flash_en_n_q;
    assign flash_we_n_o   = 1'b1;
    assign flash_vpen_o   = 1'b1;
    assign flash_byte_n_o = 1'b1;
    assign flash_rp_n_o   = run_q;
    assign eth_pwrst_n_o  = run_q;
    assign eth_cmd_o      = eth_cmd_q;
    assign eth_cs_n_o     = eth_cs_n_q;
    assign eth_ior_n_o    = eth_ior_n_q;
    assign eth_iow_n_o    = eth_iow_n_q;
    assign eth_sd_io      = eth_sd_oe_q ? eth_sd_q : 16'hzzzz;

endmodule

// File: tb/tb_ethernet_flash_gpio_if.sv
// Bench for the ThinPad peripheral bridge: directed vector table, hand-built corner
// sequences and random accesses against a transaction-level model of the board.
`timescale 1ns / 1ps

module tb_ethernet_flash_gpio_if;
    localparam int FW = 6;
    localparam int EW = 4;
    localparam int ER = 2;
    localparam int Gap = ER + 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] dip_sw;
    logic [15:0] leds;
    logic [7:0]  dpy0, dpy1;
    logic [22:0] flash_a;
    wire  [15:0] flash_d;
    logic        flash_ce_n, flash_oe_n, flash_we_n, flash_rp_n, flash_vpen, flash_byte_n;
    logic        eth_cmd, eth_cs_n, eth_ior_n, eth_iow_n, eth_pwrst_n, eth_int;
    wire  [15:0] eth_sd;

    logic [15:0] flash_mem [256];
    logic [15:0] eth_rd_val;

    ethernet_flash_gpio_if_if bus_if ();

    ethernet_flash_gpio_if #(
        .FLASH_WAIT (FW),
        .ETH_WAIT   (EW),
        .ETH_RECOVER(ER)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus_if),
        .dip_sw_i      (dip_sw),
        .leds_o        (leds),
        .dpy0_o        (dpy0),
        .dpy1_o        (dpy1),
        .flash_a_o     (flash_a),
        .flash_d_io    (flash_d),
        .flash_ce_n_o  (flash_ce_n),
        .flash_oe_n_o  (flash_oe_n),
        .flash_we_n_o  (flash_we_n),
        .flash_rp_n_o  (flash_rp_n),
        .flash_vpen_o  (flash_vpen),
        .flash_byte_n_o(flash_byte_n),
        .eth_cmd_o     (eth_cmd),
        .eth_cs_n_o    (eth_cs_n),
        .eth_ior_n_o   (eth_ior_n),
        .eth_iow_n_o   (eth_iow_n),
        .eth_pwrst_n_o (eth_pwrst_n),
        .eth_sd_io     (eth_sd),
        .eth_int_i     (eth_int)
    );

    always #10 clk = ~clk;

    // Board models: flash and Ethernet controller drive data only while read-strobed.
    assign flash_d = (!flash_ce_n && !flash_oe_n) ? flash_mem[flash_a[8:1]] : 16'hzzzz;
    assign eth_sd  = (!eth_cs_n && !eth_ior_n) ? eth_rd_val : 16'hzzzz;

    int n_checks = 0;
    int n_fail   = 0;
    int overlap  = 0;
    int ready_seen = 0;
    int we_low   = 0;

    always @(negedge clk) begin
        if (!eth_ior_n && !eth_iow_n) overlap++;
        if ((!eth_ior_n || !eth_iow_n) && !flash_oe_n) overlap++;
        if (bus_if.bus_ready) ready_seen++;
        if (!flash_we_n) we_low++;
    end

    // Results of the most recent access
    logic [31:0] r_rdata;
    int          r_lat, r_oe, r_ior, r_iow, r_cmdbad;
    logic [22:0] r_fa;
    logic [15:0] r_sd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one request (caller is #1 after an edge) and waits for ready.
    task automatic access(input logic rd, input logic wr, input logic [23:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
        logic done;
        done = 1'b0;
        r_lat = 0; r_oe = 0; r_ior = 0; r_iow = 0; r_cmdbad = 0;
        r_rdata = '0; r_fa = '0; r_sd = '0;
        bus_if.bus_addr  = a;
        bus_if.bus_wdata = wd;
        bus_if.bus_be    = be;
        bus_if.bus_read  = rd;
        bus_if.bus_write = wr;
        @(posedge clk);
        for (int n = 1; n <= 60 && !done; n++) begin
            @(negedge clk);
            if (!flash_ce_n && !flash_oe_n) begin
                r_oe++;
                r_fa = flash_a;
            end
            if (!eth_cs_n && !eth_ior_n) r_ior++;
            if (!eth_cs_n && !eth_iow_n) begin
                r_iow++;
                r_sd = eth_sd;
            end
            if ((!eth_ior_n || !eth_iow_n) && eth_cmd !== a[2]) r_cmdbad++;
            if (bus_if.bus_ready) begin
                done    = 1'b1;
                r_lat   = n;
                r_rdata = bus_if.bus_rdata;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: no bus_ready for addr %h within 60 cycles", a);
        end
        @(posedge clk);
        #1;
        bus_if.bus_read  = 1'b0;
        bus_if.bus_write = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"}, {31'b0, bus_if.bus_ready}, 32'h0);
        check({tag, "_rdata"}, bus_if.bus_rdata, 32'h0);
        check({tag, "_pins"}, {leds, dpy1, dpy0}, 32'h0);
        check({tag, "_strobes"}, {26'b0, flash_ce_n, flash_oe_n, flash_we_n, eth_cs_n,
              eth_ior_n, eth_iow_n}, 32'h3f);
        check({tag, "_rst_pins"}, {30'b0, flash_rp_n, eth_pwrst_n}, 32'h0);
        check({tag, "_static"}, {30'b0, flash_vpen, flash_byte_n}, 32'h3);
        check({tag, "_cmd_a"}, {8'b0, eth_cmd, flash_a}, 32'h0);
    endtask

    typedef struct {
        logic        rd;
        logic        wr;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        irq;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_oe;
        int          exp_ior;
        int          exp_iow;
        logic [31:0] exp_pins;  // {leds, dpy1, dpy0}
    } vec_t;

    vec_t vecs[16];

    // Transaction-level model state
    logic [15:0] m_leds;
    logic [7:0]  m_dpy0, m_dpy1;

    initial begin
        logic [31:0] exp_rd;
        int          exp_lat, exp_oe, exp_ior, exp_iow, snap;
        logic        rd, wr;
        logic [23:0] a;
        logic [31:0] wd;
        logic [3:0]  be;

        vecs[0]  = '{1, 0, 24'h000000, 32'h0,    4'h0, 0, 32'hA5A5_0F0F, 1, 0, 0, 0, 32'h0000_0000};
        vecs[1]  = '{0, 1, 24'h000004, 32'h1234, 4'h1, 0, 32'h0,         1, 0, 0, 0, 32'h0034_0000};
        vecs[2]  = '{1, 0, 24'h000004, 32'h0,    4'h0, 0, 32'h0000_0034, 1, 0, 0, 0, 32'h0034_0000};
        vecs[3]  = '{1, 1, 24'h000008, 32'h5A,   4'h1, 0, 32'h0,         1, 0, 0, 0, 32'h0034_005A};
        vecs[4]  = '{1, 0, 24'h000008, 32'h0,    4'h0, 0, 32'h0000_005A, 1, 0, 0, 0, 32'h0034_005A};
        vecs[5]  = '{0, 1, 24'h00000C, 32'h77,   4'h0, 0, 32'h0,         1, 0, 0, 0, 32'h0034_005A};
        vecs[6]  = '{0, 1, 24'h00000C, 32'hC3,   4'h1, 0, 32'h0,         1, 0, 0, 0, 32'h0034_C35A};
        vecs[7]  = '{1, 0, 24'h00000C, 32'h0,    4'h0, 0, 32'h0000_00C3, 1, 0, 0, 0, 32'h0034_C35A};
        vecs[8]  = '{0, 1, 24'h000004, 32'hABCD, 4'h2, 0, 32'h0,         1, 0, 0, 0, 32'hAB34_C35A};
        vecs[9]  = '{1, 0, 24'h000010, 32'h0,    4'h0, 1, 32'h0000_0001, 1, 0, 0, 0, 32'hAB34_C35A};
        vecs[10] = '{1, 0, 24'hC00000, 32'h0,    4'h0, 0, 32'h0,         1, 0, 0, 0, 32'hAB34_C35A};
        vecs[11] = '{1, 0, 24'h400006, 32'h0,    4'h0, 0, 32'h0000_BEEF, 7, 6, 0, 0, 32'hAB34_C35A};
        vecs[12] = '{0, 1, 24'h400000, 32'h1111, 4'hF, 0, 32'h0,         1, 0, 0, 0, 32'hAB34_C35A};
        vecs[13] = '{0, 1, 24'h800000, 32'h2A,   4'h0, 0, 32'h0,         5, 0, 0, 4, 32'hAB34_C35A};
        vecs[14] = '{1, 0, 24'h800004, 32'h0,    4'h0, 0, 32'h0000_0A46, 5, 0, 4, 0, 32'hAB34_C35A};
        vecs[15] = '{1, 0, 24'h00001C, 32'h0,    4'h0, 0, 32'h0,         1, 0, 0, 0, 32'hAB34_C35A};

        rst_n = 1'b0;
        bus_if.bus_read = 1'b0; bus_if.bus_write = 1'b0;
        bus_if.bus_addr = '0; bus_if.bus_wdata = '0; bus_if.bus_be = '0;
        dip_sw = 32'hA5A5_0F0F;
        eth_int = 1'b0;
        eth_rd_val = 16'h0A46;
        for (int i = 0; i < 256; i++) flash_mem[i] = 16'($urandom);
        flash_mem[3] = 16'hBEEF;

        repeat (3) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_pins_release", {30'b0, flash_rp_n, eth_pwrst_n}, 32'h3);

        foreach (vecs[i]) begin
            idle(Gap);
            eth_int = vecs[i].irq;
            access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
            check($sformatf("vec%0d_rdata", i), r_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_lat", i), 32'(r_lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_pins", i), {leds, dpy1, dpy0}, vecs[i].exp_pins);
            check($sformatf("vec%0d_strobes", i), {8'(r_oe), 8'(r_ior), 8'(r_iow), 8'(r_cmdbad)},
                  {8'(vecs[i].exp_oe), 8'(vecs[i].exp_ior), 8'(vecs[i].exp_iow), 8'h0});
            if (vecs[i].exp_oe > 0)
                check($sformatf("vec%0d_flash_a", i), {9'b0, r_fa},
                      {9'b0, vecs[i].addr[21:1], 1'b0});
            if (vecs[i].exp_iow > 0)
                check($sformatf("vec%0d_eth_sd", i), {16'b0, r_sd}, {16'b0, vecs[i].wdata[15:0]});
        end
        check("flash_we_never_low", 32'(we_low), 32'h0);

        // Second Ethernet request presented during recovery must wait it out
        idle(Gap);
        access(1'b0, 1'b1, 24'h800000, 32'h0000_0055, 4'hF);
        check("b2b_first_lat", 32'(r_lat), 32'(EW + 1));
        access(1'b1, 1'b0, 24'h800004, 32'h0, 4'h0);
        check("b2b_second_lat", 32'(r_lat), 32'(EW + 1 + ER));
        check("b2b_second_rdata", r_rdata, 32'h0000_0A46);
        check("b2b_second_ior", 32'(r_ior), 32'(EW));
        check("strobe_overlap", 32'(overlap), 32'h0);

        // Random accesses against the board model
        m_leds = 16'hAB34; m_dpy0 = 8'h5A; m_dpy1 = 8'hC3;
        for (int it = 0; it < 80; it++) begin
            idle(Gap);
            dip_sw     = $urandom;
            eth_int    = 1'($urandom);
            eth_rd_val = 16'($urandom);
            case ($urandom_range(2, 0))
                0:       begin rd = 1'b1; wr = 1'b0; end
                1:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            a  = 24'($urandom);
            wd = $urandom;
            be = 4'($urandom);
            exp_rd = 32'h0; exp_lat = 1; exp_oe = 0; exp_ior = 0; exp_iow = 0;
            case (a[23:22])
                2'b00: begin
                    if (wr) begin
                        if (a[4:2] == 3'd1 && be[0]) m_leds[7:0] = wd[7:0];
                        if (a[4:2] == 3'd1 && be[1]) m_leds[15:8] = wd[15:8];
                        if (a[4:2] == 3'd2 && be[0]) m_dpy0 = wd[7:0];
                        if (a[4:2] == 3'd3 && be[0]) m_dpy1 = wd[7:0];
                    end else begin
                        case (a[4:2])
                            3'd0:    exp_rd = dip_sw;
                            3'd1:    exp_rd = {16'b0, m_leds};
                            3'd2:    exp_rd = {24'b0, m_dpy0};
                            3'd3:    exp_rd = {24'b0, m_dpy1};
                            3'd4:    exp_rd = {31'b0, eth_int};
                            default: exp_rd = 32'h0;
                        endcase
                    end
                end
                2'b01: if (!wr) begin
                    exp_rd = {16'b0, flash_mem[a[8:1]]};
                    exp_lat = FW + 1;
                    exp_oe = FW;
                end
                2'b10: begin
                    exp_lat = EW + 1;
                    if (wr) exp_iow = EW;
                    else begin
                        exp_ior = EW;
                        exp_rd = {16'b0, eth_rd_val};
                    end
                end
                default: ;
            endcase
            access(rd, wr, a, wd, be);
            check($sformatf("rnd%0d_rdata", it), r_rdata, exp_rd);
            check($sformatf("rnd%0d_lat", it), 32'(r_lat), 32'(exp_lat));
            check($sformatf("rnd%0d_pins", it), {leds, dpy1, dpy0}, {m_leds, m_dpy1, m_dpy0});
            check($sformatf("rnd%0d_strobes", it), {8'(r_oe), 8'(r_ior), 8'(r_iow), 8'(r_cmdbad)},
                  {8'(exp_oe), 8'(exp_ior), 8'(exp_iow), 8'h0});
            if (exp_iow > 0) check($sformatf("rnd%0d_eth_sd", it), {16'b0, r_sd}, {16'b0, wd[15:0]});
        end

        // Reset in the third strobe cycle of a flash read
        idle(Gap);
        bus_if.bus_addr = 24'h400006;
        bus_if.bus_read = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #5;
        check("mid_oe_low", {31'b0, flash_oe_n}, 32'h0);
        snap = ready_seen;
        rst_n = 1'b0;
        #1;
        check("mid_async_strobes", {30'b0, flash_ce_n, flash_oe_n}, 32'h3);
        bus_if.bus_read = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("mid_reset");
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("mid_no_ready", 32'(ready_seen - snap), 32'h0);
        @(posedge clk);
        #1;
        dip_sw = 32'h1357_9BDF;
        access(1'b1, 1'b0, 24'h000000, 32'h0, 4'h0);
        check("post_reset_gpio_rdata", r_rdata, 32'h1357_9BDF);
        check("post_reset_gpio_lat", 32'(r_lat), 32'h1);
        idle(Gap);
        access(1'b1, 1'b0, 24'h400006, 32'h0, 4'h0);
        check("post_reset_flash_rdata", r_rdata, 32'h0000_BEEF);
        check("post_reset_flash_lat", 32'(r_lat), 32'(FW + 1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
